// File: rtl/mag_peak_detect.sv
// Windowed peak / threshold tracker for the sqrt magnitude stream: peak value, peak position and over-threshold count per WIN_LEN samples.
// Optional macro MAG_ROUND_EN rounds each integer root to nearest using the remainder; undefined -> plain truncation.
module mag_peak_detect #(
    parameter int WIN_LEN = 16,
    parameter int IDX_W   = 8,
    parameter int THRESH  = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vld,
    input  logic [7:0]       sqrt,
    input  logic [15:0]      remain,
    input  logic             clr,
    output logic             o_vld,
    output logic [7:0]       peak,
    output logic [IDX_W-1:0] peak_idx,
    output logic [IDX_W:0]   over_cnt,
    output logic             o_over
);

    localparam logic [7:0]       THR_8    = 8'(THRESH);
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(WIN_LEN - 1);

    typedef enum logic {
        S_EMPTY,
        S_FILL
    } state_t;

    logic [7:0] w_mag;

`ifdef MAG_ROUND_EN
    // N - s^2 > s  <=>  N >= (s+0.5)^2; never step past 255.
    logic w_round_up;
    assign w_round_up = ({8'd0, sqrt} < remain) && (sqrt != 8'hFF);
    assign w_mag      = sqrt + {7'd0, w_round_up};
`else
    wire w_unused_remain = ^remain;
    assign w_mag = sqrt;
`endif

    logic [7:0] r_mag;
    logic       r_v1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag <= '0;
            r_v1  <= 1'b0;
        end else begin
            // A sample presented with clr is dropped before it reaches the accumulator.
            r_v1 <= i_vld & ~clr;
            if (i_vld) begin
                r_mag <= w_mag;
            end
        end
    end

    state_t           r_state;
    logic [IDX_W-1:0] r_cnt;
    logic [7:0]       r_cur_peak;
    logic [IDX_W-1:0] r_cur_idx;
    logic [IDX_W:0]   r_cur_over;
    logic             r_o_vld;
    logic [7:0]       r_peak;
    logic [IDX_W-1:0] r_peak_idx;
    logic [IDX_W:0]   r_over_cnt;
    logic             r_o_over;

    logic             w_mag_ge;
    logic             w_new_max;
    logic [7:0]       w_peak_next;
    logic [IDX_W-1:0] w_idx_next;
    logic [IDX_W:0]   w_over_next;
    logic             w_win_done;

    assign w_mag_ge    = (r_mag >= THR_8);
    assign w_new_max   = (r_mag > r_cur_peak);
    assign w_peak_next = w_new_max ? r_mag : r_cur_peak;
    assign w_idx_next  = w_new_max ? r_cnt : r_cur_idx;
    assign w_over_next = r_cur_over + {{IDX_W{1'b0}}, w_mag_ge};
    assign w_win_done  = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_cnt      <= '0;
            r_cur_peak <= '0;
            r_cur_idx  <= '0;
            r_cur_over <= '0;
            r_o_vld    <= 1'b0;
            r_peak     <= '0;
            r_peak_idx <= '0;
            r_over_cnt <= '0;
            r_o_over   <= 1'b0;
        end else begin
            r_o_vld <= 1'b0;
            if (clr) begin
                // Registered results and the pulse already on o_vld are left alone.
                r_state    <= S_EMPTY;
                r_cnt      <= '0;
                r_cur_peak <= '0;
                r_cur_idx  <= '0;
                r_cur_over <= '0;
            end else if (r_v1) begin
                case (r_state)
                    S_EMPTY: begin
                        r_cur_peak <= r_mag;
                        r_cur_idx  <= '0;
                        r_cur_over <= {{IDX_W{1'b0}}, w_mag_ge};
                        r_cnt      <= IDX_W'(1);
                        r_state    <= S_FILL;
                    end
                    S_FILL: begin
                        if (w_win_done) begin
                            r_peak     <= w_peak_next;
                            r_peak_idx <= w_idx_next;
                            r_over_cnt <= w_over_next;
                            r_o_over   <= (w_peak_next >= THR_8);
                            r_o_vld    <= 1'b1;
                            r_cnt      <= '0;
                            r_cur_peak <= '0;
                            r_cur_idx  <= '0;
                            r_cur_over <= '0;
                            r_state    <= S_EMPTY;
                        end else begin
                            r_cur_peak <= w_peak_next;
                            r_cur_idx  <= w_idx_next;
                            r_cur_over <= w_over_next;
                            r_cnt      <= r_cnt + IDX_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_EMPTY;
                    end
                endcase
            end
        end
    end

    assign o_vld    = r_o_vld;
    assign peak     = r_peak;
    assign peak_idx = r_peak_idx;
    assign over_cnt = r_over_cnt;
    assign o_over   = r_o_over;

endmodule

// File: doc/mag_peak_detect.md
Name: mag_peak_detect

Overview:
- Downstream consumer of the magnitude stage that computes sqrt(a^2+b^2) and emits o_vld / sqrt[7:0] / remain[15:0].
- Optionally rounds each integer root to the nearest integer using the remainder.
- Tracks the peak magnitude, the position of that peak, and the count of samples at or above a threshold over fixed windows of WIN_LEN valid samples.
- Emits one result pulse per window for the downstream alarm/report logic.

Parameters:
- WIN_LEN, 16: valid samples per window; legal range 2..2^IDX_W.
- IDX_W, 8: width of the peak index and counters.
- THRESH, 100: magnitude threshold, unsigned, 8 bit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_vld  in  1  sample valid; driven by the upstream o_vld
- sqrt  in  8  integer root from upstream
- remain  in  16  root remainder from upstream
- clr  in  1  synchronous window restart
- o_vld  out  1  one-cycle pulse; window result valid
- peak  out  8  maximum magnitude in the window
- peak_idx  out  IDX_W  sample position of the peak, 0-based within the window
- over_cnt  out  IDX_W+1  number of samples with magnitude >= THRESH
- o_over  out  1  1 when peak >= THRESH

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, all internal state 0, FSM in EMPTY.
- Input protocol: no backpressure. A sample is accepted on any cycle with i_vld=1. Gaps of any length between samples are legal.
- Stage 1 (registered), per accepted sample:
  - mag_r <= mag, where mag is defined under Optional Feature.
  - v1 <= i_vld.
- Stage 2: window accumulator FSM with a sample counter cnt (IDX_W bits).
  - EMPTY (cnt=0, no sample held). On v1:
    - cur_peak <= mag_r, cur_idx <= 0, cur_over <= (mag_r >= THRESH).
    - cnt <= 1, go to FILL.
    - If WIN_LEN were 1 the window would close here; WIN_LEN=1 is illegal.
  - FILL. On v1:
    - If mag_r > cur_peak (strictly greater): cur_peak <= mag_r, cur_idx <= cnt. Ties keep the earliest index.
    - cur_over increments when mag_r >= THRESH.
    - If cnt == WIN_LEN-1: the window closes.
      - Register outputs: peak, peak_idx, over_cnt, o_over, computed with the current sample included.
      - o_vld <= 1 for one cycle.
      - cnt <= 0, go to EMPTY.
    - Otherwise cnt <= cnt+1.
- Latency: last sample on i_vld at cycle T produces o_vld high at T+2.
  - Back-to-back windows lose no samples.
  - A new window's first sample may arrive at T+1.
- Output hold: peak, peak_idx, over_cnt and o_over hold their values until the next window closes. o_vld is 0 on all other cycles.
- clr (synchronous, highest priority):
  - Discards the sample presented in the same cycle and the sample in stage 1.
  - Returns to EMPTY with cnt, cur_* cleared.
  - Does not alter already-registered outputs or an o_vld pulse issued that cycle.
- Reset mid-window: asynchronous clear of everything. The partial window is lost and no o_vld is issued.
- Widths:
  - Magnitude is at most 181, since the input sum is at most 32768; no overflow into 8 bits.
  - The rounding add saturates at 255 as a safeguard.
  - over_cnt is at most WIN_LEN and fits IDX_W+1 bits.

Optional Feature:
- Macro: MAG_ROUND_EN.
- Defined: mag = sqrt + 1 when remain > sqrt, else sqrt (round to nearest).
  - Rationale: (s+0.5)^2 = s^2+s+0.25, so an integer N rounds up iff N-s^2 > s.
  - Saturates at 255.
- Undefined: mag = sqrt (truncation). remain is ignored and the comparator/incrementer are not built.
- Latency is identical in both builds.

Test Plan:
(All scenarios use WIN_LEN=4, THRESH=100, MAG_ROUND_EN undefined unless stated.)
1. Reset -> o_vld, peak, peak_idx, over_cnt and o_over all 0. Stream sqrt 10,50,30,50 (remain 0) on 4 consecutive cycles -> single o_vld pulse 2 cycles after the 4th sample; peak=50, peak_idx=1 (tie keeps first), over_cnt=0, o_over=0.
2. Same four samples with 3 idle cycles between each -> identical results; o_vld 2 cycles after the last sample.
3. MAG_ROUND_EN defined: window of (sqrt 100, remain 100), (99, 200), (0, 0), (181, 7) -> magnitudes 100, 100, 0, 181; peak=181, peak_idx=3, over_cnt=3, o_over=1. Same stimulus with the macro undefined -> magnitudes 100, 99, 0, 181; over_cnt=2.
4. Two samples (sqrt 150, 150), then clr asserted together with a third sample, then 4 samples of sqrt 20 -> exactly one o_vld pulse; peak=20, peak_idx=0, over_cnt=0. Outputs are unchanged before that pulse.
5. 8 consecutive samples: 1,2,3,4 then 181,181,181,181 -> two o_vld pulses 4 cycles apart. First: peak=4, idx=3. Second: peak=181, idx=0, over_cnt=4, o_over=1.
6. rst_n asserted asynchronously after 3 samples of a window -> no o_vld pulse. After release, 4 samples of sqrt 7 -> peak=7, idx=0.
